// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - Shared state type and index-width helper for the uart_tx arbiter
package uart_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_GRANT     = 3'd1,
    ARB_LAUNCH    = 3'd2,
    ARB_WAIT_DONE = 3'd3,
    ARB_RELEASE   = 3'd4
  } arb_state_t;

  localparam int UART_ARB_MIN_CNT_W = 8;

  function automatic int UART_ARB_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - Combinational round-robin winner search starting at rr_ptr
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = UART_ARB_IDX_W(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IW-1:0]    rr_ptr_i,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to rr_ptr so the nearest valid one wins.
  always_comb begin
    idx_o = rr_ptr_i;
    any_o = 1'b0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(rr_ptr_i) + i) % N_REQ);
      if (valid_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - Round-robin sharing of one uart_tx; UART_ARB_TMO_EN adds a LAUNCH watchdog
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DATA_WDTH = 8,
  parameter  int TMO_CYC   = 64,
  localparam int IW        = UART_ARB_IDX_W(N_REQ)
) (
  input  logic                       CLKip,
  input  logic                       RSTNi,
  input  logic [N_REQ-1:0]           REQ_VALIDi,
  input  logic [N_REQ*DATA_WDTH-1:0] REQ_DATAi,
  output logic [N_REQ-1:0]           REQ_READYo,
  output logic [N_REQ-1:0]           REQ_DONEo,
  output logic [IW-1:0]              GRANT_IDXo,
  output logic                       ARB_ACTIVEo,
  output logic [DATA_WDTH-1:0]       UTX_DATAo,
  output logic                       UTX_ENo,
  input  logic                       UTX_BUSYi,
  input  logic                       UTX_DONEi
`ifdef UART_ARB_TMO_EN
  ,
  output logic                       TMO_ERRo
`endif
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_WDTH-1:0] data_q, data_d;
  logic                 en_q, en_d;
  logic [N_REQ-1:0]     ready_q, ready_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic                 active_q;
  logic                 busy_q;

  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [N_REQ-1:0]     grant_oh;
  logic [IW-1:0]        next_ptr;

`ifdef UART_ARB_TMO_EN
  localparam int CNT_W = ($clog2(TMO_CYC + 1) > UART_ARB_MIN_CNT_W) ?
                         $clog2(TMO_CYC + 1) : UART_ARB_MIN_CNT_W;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`else
  // The watchdog limit has no consumer without the timeout logic.
  logic unused_tmo_cyc;
  assign unused_tmo_cyc = (TMO_CYC != 0);
`endif

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .valid_i  (REQ_VALIDi),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign grant_oh = ONE_HOT0 << grant_q;
  assign next_ptr = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    en_d     = 1'b0;
    ready_d  = '0;
    done_d   = '0;
`ifdef UART_ARB_TMO_EN
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        data_d  = REQ_DATAi[int'(grant_q)*DATA_WDTH +: DATA_WDTH];
        ready_d = grant_oh;
        state_d = ARB_LAUNCH;
`ifdef UART_ARB_TMO_EN
        cnt_d   = '0;
`endif
      end
      // Enable must drop as soon as busy is seen, or uart_tx would relaunch.
      ARB_LAUNCH: begin
        if (UTX_BUSYi) begin
          state_d = ARB_WAIT_DONE;
        end
`ifdef UART_ARB_TMO_EN
        else if (cnt_q == CNT_W'(TMO_CYC)) begin
          tmo_d    = 1'b1;
          rr_ptr_d = next_ptr;
          state_d  = ARB_IDLE;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
`else
        else begin
          en_d = 1'b1;
        end
`endif
      end
      // DONE is a level left over from the previous frame; only a busy fall counts.
      ARB_WAIT_DONE: begin
        if (busy_q && !UTX_BUSYi && UTX_DONEi) begin
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        done_d   = grant_oh;
        rr_ptr_d = next_ptr;
        state_d  = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      ready_q  <= '0;
      done_q   <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      en_q     <= en_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      active_q <= (state_d != ARB_IDLE);
      busy_q   <= UTX_BUSYi;
    end
  end

`ifdef UART_ARB_TMO_EN
  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign TMO_ERRo = tmo_q;
`endif

  assign REQ_READYo  = ready_q;
  assign REQ_DONEo   = done_q;
  assign GRANT_IDXo  = grant_q;
  assign ARB_ACTIVEo = active_q;
  assign UTX_DATAo   = data_q;
  assign UTX_ENo     = en_q;

endmodule
